// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch/operand sequencer driving the program counter strobes
//
// Fetches the reset vector, then opcodes plus 0-2 operand bytes, steering
// absolute-jump operands into the PC and handing other instructions to execute.
// Optional build macro PC_FETCH_CTRL_RETIRE_CNT_EN adds the retire_cnt output.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   mem_ready, data_in    memory read handshake and data
//   dec_len, dec_jump     combinational decode of data_in (length, absolute jump)
//   exec_done             execute unit finished the current instruction
//   halt_req, resume      halt at next instruction boundary / leave HALT
//   addr_sel, vec_addr    memory address source (0 = PC, 1 = vec_addr)
//   pc_branch             PC <= {pc_bra_add, low-byte buffer}
//   pc_increment          PC <= PC + 1
//   pc_lower_byte         low-byte buffer <= pc_bra_add
//   pc_bra_add            byte for the PC (mirrors data_in)
//   ir_load, opnd_load    instruction / operand register loads
//   exec_start            one-cycle pulse handing the instruction to execute
//   halted                high while in HALT
//   retire_cnt            retired instruction count (optional)
module pc_fetch_ctrl #(
    parameter logic [15:0] VECTOR_ADDR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ready,
    input  logic [7:0]  data_in,
    input  logic [1:0]  dec_len,
    input  logic        dec_jump,
    input  logic        exec_done,
    input  logic        halt_req,
    input  logic        resume,
    output logic        addr_sel,
    output logic [15:0] vec_addr,
    output logic        pc_branch,
    output logic        pc_increment,
    output logic        pc_lower_byte,
    output logic [7:0]  pc_bra_add,
    output logic        ir_load,
    output logic [1:0]  opnd_load,
    output logic        exec_start,
    output logic        halted
`ifdef PC_FETCH_CTRL_RETIRE_CNT_EN
    ,
    output logic [15:0] retire_cnt
`endif
);

    typedef enum logic [2:0] {VEC_LO, VEC_HI, FETCH, OPND1, OPND2, JMP_HI, EXEC, HALT} state_t;

    state_t     state, state_d;
    logic [1:0] len_q;
    logic       jump_q;
    logic       exec_first;
    logic [1:0] len_d;
    logic       fire;

    assign len_d = (dec_len == 2'd0) ? 2'd1 : dec_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= VEC_LO;
            len_q      <= 2'd1;
            jump_q     <= 1'b0;
            exec_first <= 1'b0;
        end else begin
            state      <= state_d;
            exec_first <= (state_d == EXEC) && (state != EXEC);
            if (state == FETCH && mem_ready) begin
                len_q  <= len_d;
                jump_q <= dec_jump && (dec_len == 2'd3);
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            VEC_LO:  state_d = mem_ready ? VEC_HI : VEC_LO;
            VEC_HI:  state_d = mem_ready ? FETCH : VEC_HI;
            FETCH:   state_d = !mem_ready ? FETCH : (len_d == 2'd1) ? EXEC : OPND1;
            OPND1:   state_d = !mem_ready ? OPND1 : jump_q ? JMP_HI : (len_q == 2'd2) ? EXEC : OPND2;
            OPND2:   state_d = mem_ready ? EXEC : OPND2;
            JMP_HI:  state_d = mem_ready ? FETCH : JMP_HI;
            EXEC:    state_d = !exec_done ? EXEC : halt_req ? HALT : FETCH;
            HALT:    state_d = resume ? FETCH : HALT;
            default: state_d = VEC_LO;
        endcase
    end

    // Strobes are Mealy on mem_ready so the PC acts on the edge where data is valid;
    // rst gates them because the state register only settles asynchronously.
    assign fire = mem_ready && !rst;

    always_comb begin
        addr_sel      = (state == VEC_LO) || (state == VEC_HI);
        vec_addr      = (state == VEC_HI) ? VECTOR_ADDR + 16'd1 : VECTOR_ADDR;
        pc_bra_add    = data_in;
        pc_lower_byte = fire && ((state == VEC_LO) || (state == OPND1 && jump_q));
        pc_branch     = fire && ((state == VEC_HI) || (state == JMP_HI));
        pc_increment  = fire && ((state == FETCH) || (state == OPND1) || (state == OPND2));
        ir_load       = fire && (state == FETCH);
        opnd_load     = {fire && ((state == OPND2) || (state == JMP_HI)), fire && (state == OPND1)};
        exec_start    = !rst && (state == EXEC) && exec_first;
        halted        = !rst && (state == HALT);
    end

`ifdef PC_FETCH_CTRL_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retire_cnt <= 16'd0;
        else if ((state == EXEC && exec_done) || (state == JMP_HI && mem_ready))
            retire_cnt <= retire_cnt + 16'd1;
    end
`endif

endmodule
